// File: rtl/lfsr_gen.sv
// lfsr_gen: parameterised LFSR pseudo-random generator.
//   Two selectable tap polynomials, Fibonacci or Galois structure,
//   free-run or single-step (rising-edge of en) advance, seed load,
//   all-zero lockup recovery and an on-line period measurement.
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   synchronous active-low reset
//   en       in   advance request
//   load     in   load seed (wins over a step)
//   seed     in   value to load (0 is replaced by SEED)
//   mode     in   [0] poly A/B, [1] Fibonacci/Galois, [2] free-run/single-step
//   lfsr     out  current state
//   bit_out  out  lfsr MSB
//   wrap     out  pulse: state returned to the measurement start value
//   lockup   out  pulse: zero state/seed replaced by SEED
//   period   out  last measured cycle length
module lfsr_gen #(
    parameter int               WIDTH  = 8,
    parameter logic [WIDTH-1:0] TAPS_A = 8'hB8,
    parameter logic [WIDTH-1:0] TAPS_B = 8'h8E,
    parameter logic [WIDTH-1:0] SEED   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic [2:0]       mode,
    output logic [WIDTH-1:0] lfsr,
    output logic             bit_out,
    output logic             wrap,
    output logic             lockup,
    output logic [WIDTH-1:0] period
);

    logic             en_q;
    logic [2:0]       mode_q;
    logic [WIDTH-1:0] start;
    logic [WIDTH-1:0] cnt;

    logic [WIDTH-1:0] taps;
    logic [WIDTH-1:0] fib_nxt;
    logic [WIDTH-1:0] gal_nxt;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] lfsr_nxt;
    logic [WIDTH-1:0] cnt_inc;
    logic             step;
    logic             adv;
    logic             lock_nxt;
    logic             mode_chg;

    assign bit_out = lfsr[WIDTH-1];

    always_comb begin
        taps     = mode[0] ? TAPS_B : TAPS_A;
        fib_nxt  = {lfsr[WIDTH-2:0], ^(lfsr & taps)};
        gal_nxt  = {lfsr[WIDTH-2:0], 1'b0} ^ (lfsr[WIDTH-1] ? taps : '0);
        step_val = mode[1] ? gal_nxt : fib_nxt;
        // single-step advances only on the cycle en rises
        step     = mode[2] ? (en & ~en_q) : en;
        mode_chg = (mode != mode_q);
        // saturate so a very long (or stuck) sequence never aliases to a short one
        cnt_inc  = (cnt == '1) ? cnt : cnt + 1'b1;

        lfsr_nxt = lfsr;
        lock_nxt = 1'b0;
        adv      = 1'b0;
        if (load) begin
            if (seed == '0) begin
                lfsr_nxt = SEED;
                lock_nxt = 1'b1;
            end else begin
                lfsr_nxt = seed;
            end
        end else if (step) begin
            adv = 1'b1;
            if (lfsr == '0) begin
                lfsr_nxt = SEED;
                lock_nxt = 1'b1;
            end else begin
                lfsr_nxt = step_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr   <= SEED;
            start  <= SEED;
            cnt    <= '0;
            period <= '0;
            wrap   <= 1'b0;
            lockup <= 1'b0;
            en_q   <= 1'b0;
            mode_q <= 3'b000;
        end else begin
            en_q   <= en;
            mode_q <= mode;
            lfsr   <= lfsr_nxt;
            lockup <= lock_nxt;
            wrap   <= 1'b0;
            // a load or a mode switch restarts measurement from the new state;
            // period keeps the last completed measurement
            if (load || mode_chg) begin
                start <= lfsr_nxt;
                cnt   <= '0;
            end else if (adv) begin
                if (lfsr_nxt == start) begin
                    period <= cnt_inc;
                    wrap   <= 1'b1;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: directed test of lfsr_gen at WIDTH=4.
//   Poly A = 4'h9, poly B = 4'hC (both maximal, period 15), SEED = 4'h5.
module tb_lfsr_gen;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n, en, load;
    logic [W-1:0] seed;
    logic [2:0]   mode;
    logic [W-1:0] lfsr, period;
    logic         bit_out, wrap, lockup;

    int n_tot = 0;
    int n_bad = 0;

    lfsr_gen #(
        .WIDTH (W),
        .TAPS_A(4'h9),
        .TAPS_B(4'hC),
        .SEED  (4'h5)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .load   (load),
        .seed   (seed),
        .mode   (mode),
        .lfsr   (lfsr),
        .bit_out(bit_out),
        .wrap   (wrap),
        .lockup (lockup),
        .period (period)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // one clock; outputs sampled 1 time unit after the edge, inputs changed there too
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] fib_a [15] = '{4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5, 4'hB,
                                 4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8, 4'h1};
    logic [W-1:0] gal_a [15] = '{4'h2, 4'h4, 4'h8, 4'h9, 4'hB, 4'hF, 4'h7, 4'hE,
                                 4'h5, 4'hA, 4'hD, 4'h3, 4'h6, 4'hC, 4'h1};
    // Fibonacci poly B starting after E
    logic [W-1:0] fib_b [15] = '{4'hC, 4'h8, 4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6,
                                 4'hD, 4'hA, 4'h5, 4'hB, 4'h7, 4'hF, 4'hE};

    initial begin
        rst_n = 1'b0; en = 1'b0; load = 1'b0; seed = '0; mode = 3'b000;
        tick(); tick();
        chk("rst_lfsr",   lfsr,    4'h5);
        chk("rst_bit",    bit_out, 1'b0);
        chk("rst_wrap",   wrap,    1'b0);
        chk("rst_lockup", lockup,  1'b0);
        chk("rst_period", period,  4'h0);

        // Fibonacci, poly A
        rst_n = 1'b1; load = 1'b1; seed = 4'h1;
        tick();
        chk("fib_load", lfsr, 4'h1);
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk($sformatf("fib_%0d", i), lfsr, fib_a[i]);
            chk($sformatf("fib_wrap_%0d", i), wrap, (i == 14));
            if (i == 2) chk("fib_bit", bit_out, 1'b1);
        end
        chk("fib_period", period, 4'hF);

        // Galois, poly A; load and mode change in the same cycle
        en = 1'b0; load = 1'b1; seed = 4'h1; mode = 3'b010;
        tick();
        chk("gal_load",   lfsr,   4'h1);
        chk("gal_perkeep", period, 4'hF);
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk($sformatf("gal_%0d", i), lfsr, gal_a[i]);
            chk($sformatf("gal_wrap_%0d", i), wrap, (i == 14));
        end
        chk("gal_period", period, 4'hF);

        // zero seed substitution
        en = 1'b0; load = 1'b1; seed = 4'h0;
        tick();
        chk("zero_lfsr",   lfsr,   4'h5);
        chk("zero_lockup", lockup, 1'b1);
        chk("zero_wrap",   wrap,   1'b0);
        load = 1'b0;
        tick();
        chk("zero_lockup_end", lockup, 1'b0);
        chk("zero_hold", lfsr, 4'h5);

        // single-step
        mode = 3'b100; load = 1'b1; seed = 4'h1;
        tick();
        load = 1'b0; en = 1'b1;
        tick();
        chk("ss_first", lfsr, 4'h3);
        for (int i = 0; i < 4; i++) tick();
        chk("ss_held", lfsr, 4'h3);
        en = 1'b0;
        tick();
        chk("ss_low", lfsr, 4'h3);
        en = 1'b1;
        tick();
        chk("ss_second", lfsr, 4'h7);
        en = 1'b0;
        tick();
        chk("ss_idle", lfsr, 4'h7);

        // precedence: load beats step, reset beats everything
        mode = 3'b000; load = 1'b1; en = 1'b1; seed = 4'h9;
        tick();
        chk("prec_load", lfsr, 4'h9);
        load = 1'b0;
        tick();
        chk("prec_step", lfsr, 4'h2);
        rst_n = 1'b0; load = 1'b1; seed = 4'h3;
        tick();
        chk("prec_rst_lfsr",   lfsr,   4'h5);
        chk("prec_rst_period", period, 4'h0);
        chk("prec_rst_wrap",   wrap,   1'b0);
        chk("prec_rst_lockup", lockup, 1'b0);

        // mode change mid-run: A -> B
        rst_n = 1'b1; load = 1'b1; seed = 4'h1; en = 1'b0;
        tick();
        load = 1'b0; en = 1'b1;
        tick(); tick(); tick();
        chk("mc_pre", lfsr, 4'hF);
        mode = 3'b001;
        tick();
        chk("mc_first", lfsr, 4'hE);
        chk("mc_nowrap", wrap, 1'b0);
        for (int i = 0; i < 15; i++) begin
            tick();
            chk($sformatf("mc_%0d", i), lfsr, fib_b[i]);
            chk($sformatf("mc_wrap_%0d", i), wrap, (i == 14));
            if (i == 13) chk("mc_per_hold", period, 4'h0);
        end
        chk("mc_period", period, 4'hF);
        en = 1'b0;
        tick();
        chk("mc_wrap_end", wrap, 1'b0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
